// File: rtl/dsp_systolic_pkg.sv
// Shared definitions for the systolic dot-product feeder.
//   - default parameter values for the 27x27 unsigned configuration
//   - control FSM state encoding
package dsp_systolic_pkg;

  localparam int unsigned DEF_NUM            = 10;
  localparam int unsigned DEF_AX_WIDTH       = 27;
  localparam int unsigned DEF_AY_WIDTH       = 27;
  localparam int unsigned DEF_RESULT_A_WIDTH = 64;
  localparam int unsigned DEF_CHAIN_LATENCY  = 3;
  localparam int unsigned DEF_FIFO_DEPTH     = 8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/dsp_systolic_result_fifo.sv
// Synchronous show-ahead FIFO buffering chain results.
//   clk/rst_n : clock, asynchronous active-low reset
//   wr_en     : push wr_data (accepted when not full, or full with a pop)
//   rd_en     : pop head (ignored when empty)
//   rd_data   : head entry, zero when empty
//   count     : current occupancy, 0..DEPTH
module dsp_systolic_result_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;
  logic             w_empty;
  logic             w_full;
  logic             w_do_rd;
  logic             w_do_wr;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (PW+1)'(DEPTH));
  assign w_do_rd = rd_en && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
  assign w_do_wr = wr_en && (!w_full || w_do_rd);

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + PW'(1);
      if (w_do_rd) r_rptr <= r_rptr + PW'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wptr] <= wr_data;
  end

  assign rd_data = w_empty ? '0 : r_mem[r_rptr];
  assign count   = r_count;

endmodule

// File: rtl/dsp_systolic_27x27u_feeder.sv
// Feeder for a NUM-tap systolic multiply-accumulate chain.
// Skews an accepted dot-product vector across the chain lanes (lane i one
// cycle later than lane i-1), tracks each vector through the chain latency,
// and buffers the chain result for a ready/valid consumer. Supports a
// flush/drain handshake.
//   in_ax/in_ay/in_valid/in_ready : vector input handshake
//   ax/ay                         : skewed operands to the chain (zero on bubbles)
//   result                        : chain accumulate output
//   out_result/out_valid/out_ready: result output handshake
//   flush/flush_done              : drain request / one-cycle completion pulse
module dsp_systolic_27x27u_feeder
  import dsp_systolic_pkg::*;
#(
  parameter int unsigned NUM            = DEF_NUM,
  parameter int unsigned AX_WIDTH       = DEF_AX_WIDTH,
  parameter int unsigned AY_WIDTH       = DEF_AY_WIDTH,
  parameter int unsigned RESULT_A_WIDTH = DEF_RESULT_A_WIDTH,
  parameter int unsigned CHAIN_LATENCY  = DEF_CHAIN_LATENCY,
  parameter int unsigned FIFO_DEPTH     = DEF_FIFO_DEPTH
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM-1:0][AX_WIDTH-1:0]       in_ax,
  input  logic [NUM-1:0][AY_WIDTH-1:0]       in_ay,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [NUM-1:0][AX_WIDTH-1:0]       ax,
  output logic [NUM-1:0][AY_WIDTH-1:0]       ay,
  input  logic [RESULT_A_WIDTH-1:0]          result,
  output logic [RESULT_A_WIDTH-1:0]          out_result,
  output logic                               out_valid,
  input  logic                               out_ready,
  input  logic                               flush,
  output logic                               flush_done
);

  localparam int unsigned LW = AX_WIDTH + AY_WIDTH;
  localparam int unsigned VD = NUM + CHAIN_LATENCY;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  feeder_state_e           r_state;
  logic                    r_flush_done;
  logic [NUM-1:0][LW-1:0]  w_in_lane;
  logic [NUM-1:0][LW-1:0]  r_in_lane;
  logic                    r_in_v;
  logic [VD-1:0]           r_vpipe;
  logic [CW-1:0]           r_inflight;
  logic [CW-1:0]           w_count;
  logic [CW:0]             w_load;
  logic                    w_accept;
  logic                    w_capture;
  logic                    w_pop;

  assign w_accept  = in_valid && in_ready;
  assign w_capture = r_vpipe[VD-1];
  assign w_pop     = out_valid && out_ready;
  assign w_load    = {1'b0, r_inflight} + {1'b0, w_count};

  // Gated by rst_n so in_ready is low while reset is held even though the
  // state and counters already read as idle.
  assign in_ready = rst_n && (r_state == ST_RUN) && (w_load < (CW+1)'(FIFO_DEPTH));

  always_comb begin
    w_in_lane = '0;
    for (int unsigned i = 0; i < NUM; i++) begin
      w_in_lane[i] = {in_ax[i], in_ay[i]};
    end
  end

  // Entry stage: the accepted vector, or zeros on a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_lane <= '0;
      r_in_v    <= 1'b0;
      r_vpipe   <= '0;
    end else begin
      r_in_lane <= w_accept ? w_in_lane : '0;
      r_in_v    <= w_accept;
      r_vpipe   <= {r_vpipe[VD-2:0], r_in_v};
    end
  end

  // Lane g delays the entry stage by g+1 further cycles; newest word sits at
  // the LSB end and the lane output is the oldest (top) word.
  for (genvar g = 0; g < NUM; g++) begin : g_lane
    logic [(g+1)*LW-1:0] r_dly;
    if (g == 0) begin : g_first
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_dly <= '0;
        else        r_dly <= r_in_lane[g];
      end
    end else begin : g_rest
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_dly <= '0;
        else        r_dly <= {r_dly[g*LW-1:0], r_in_lane[g]};
      end
    end
    assign ax[g] = r_dly[(g+1)*LW-1 -: AX_WIDTH];
    assign ay[g] = r_dly[g*LW +: AY_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else begin
      case ({w_accept, w_capture})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  dsp_systolic_result_fifo #(
    .WIDTH (RESULT_A_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_capture),
    .wr_data (result),
    .rd_en   (w_pop),
    .rd_data (out_result),
    .count   (w_count)
  );

  assign out_valid = (w_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RUN;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (flush) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (r_inflight == '0 && w_count == '0) begin
            r_state      <= ST_DONE;
            r_flush_done <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!flush) r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign flush_done = r_flush_done;

endmodule

// File: tb/tb_dsp_systolic_27x27u_feeder.sv
// Testbench for dsp_systolic_27x27u_feeder: models a NUM-tap systolic MAC
// chain driven by ax/ay, and checks results against a dot-product scoreboard.
module tb_dsp_systolic_27x27u_feeder;

  localparam int unsigned NUM  = 10;
  localparam int unsigned AXW  = 27;
  localparam int unsigned AYW  = 27;
  localparam int unsigned RW   = 64;
  localparam int unsigned CL   = 3;
  localparam int unsigned FD   = 8;
  localparam int unsigned NVEC = 20;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM-1:0][AXW-1:0] in_ax;
  logic [NUM-1:0][AYW-1:0] in_ay;
  logic                   in_valid;
  logic                   in_ready;
  logic [NUM-1:0][AXW-1:0] ax;
  logic [NUM-1:0][AYW-1:0] ay;
  logic [RW-1:0]          result;
  logic [RW-1:0]          out_result;
  logic                   out_valid;
  logic                   out_ready;
  logic                   flush;
  logic                   flush_done;

  dsp_systolic_27x27u_feeder #(
    .NUM            (NUM),
    .AX_WIDTH       (AXW),
    .AY_WIDTH       (AYW),
    .RESULT_A_WIDTH (RW),
    .CHAIN_LATENCY  (CL),
    .FIFO_DEPTH     (FD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_ax      (in_ax),
    .in_ay      (in_ay),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ax         (ax),
    .ay         (ay),
    .result     (result),
    .out_result (out_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .flush      (flush),
    .flush_done (flush_done)
  );

  always #5 clk = ~clk;

  // Chain model: tap i adds its product to tap i-1's partial sum of the
  // previous cycle; tap NUM-1 is the first of CL result register stages.
  logic [RW-1:0] p [NUM];
  logic [RW-1:0] d [CL-1];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM; i++) p[i] <= '0;
      for (int i = 0; i < CL-1; i++) d[i] <= '0;
    end else begin
      p[0] <= RW'(ax[0]) * RW'(ay[0]);
      for (int i = 1; i < NUM; i++) p[i] <= p[i-1] + RW'(ax[i]) * RW'(ay[i]);
      d[0] <= p[NUM-1];
      for (int i = 1; i < CL-1; i++) d[i] <= d[i-1];
    end
  end
  assign result = d[CL-2];

  typedef struct {
    logic [NUM-1:0][AXW-1:0] x;
    logic [NUM-1:0][AYW-1:0] y;
    logic [RW-1:0]           exp;
  } vec_t;
  vec_t tbl [NVEC];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pop    = 0;
  int          cyc      = 0;
  int          last_pop_edge = 0;
  logic [RW-1:0] cur_exp;
  logic [RW-1:0] sb [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] dot(input logic [NUM-1:0][AXW-1:0] x,
                                        input logic [NUM-1:0][AYW-1:0] y);
    logic [RW-1:0] s = '0;
    for (int i = 0; i < NUM; i++) s += RW'(x[i]) * RW'(y[i]);
    return s;
  endfunction

  // Scoreboard: push on accept, pop/compare on output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) sb.push_back(cur_exp);
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", RW'(out_valid), '0);
        end else if (out_ready) begin
          check("result", out_result, sb.pop_front());
          n_pop++;
          last_pop_edge = cyc + 1;
        end else begin
          check("held_result", out_result, sb[0]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NUM-1:0][AXW-1:0] x, input logic [NUM-1:0][AYW-1:0] y,
                       input logic [RW-1:0] e);
    in_ax    = x;
    in_ay    = y;
    cur_exp  = e;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept(input string name);
    bit ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (ok) tick();
    else check({name, "_accept_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic send(input int idx);
    drive(tbl[idx].x, tbl[idx].y, tbl[idx].exp);
    wait_accept($sformatf("vec%0d", idx));
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    bit ok = 1'b0;
    for (int t = 0; t < max_cyc && !ok; t++) begin
      if (sb.size() == 0 && !out_valid) ok = 1'b1;
      else tick();
    end
    if (!ok) check({name, "_drain_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM-1:0][AXW-1:0] vx;
    logic [NUM-1:0][AYW-1:0] vy;
    int base;
    int j;
    bit acc;
    bit seen;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    in_ax = '0; in_ay = '0; cur_exp = '0;

    for (int i = 0; i < NVEC; i++) begin
      for (int l = 0; l < NUM; l++) begin
        tbl[i].x[l] = (i == 0) ? '1 : (i == 1) ? '0 : AXW'($urandom);
        tbl[i].y[l] = (i == 0) ? '1 : (i == 1) ? AYW'($urandom) : AYW'($urandom);
      end
      tbl[i].exp = dot(tbl[i].x, tbl[i].y);
    end

    // Reset state
    repeat (3) tick();
    check("rst_in_ready", RW'(in_ready), 0);
    check("rst_out_valid", RW'(out_valid), 0);
    check("rst_out_result", out_result, 0);
    check("rst_flush_done", RW'(flush_done), 0);
    check("rst_axay_zero", RW'(ax == '0 && ay == '0), 1);
    @(negedge clk); rst_n = 1'b1;
    tick();
    check("in_ready_after_rst", RW'(in_ready), 1);

    // Single vector: lane timing and first-result latency
    for (int i = 0; i < NUM; i++) begin
      vx[i] = AXW'(i + 1);
      vy[i] = AYW'(2);
    end
    drive(vx, vy, 64'd110);
    @(negedge clk);
    check("single_in_ready", RW'(in_ready), 1);
    tick();                       // edge 0: accept
    in_valid = 1'b0;              // in_ax left non-zero: bubbles must still be zero
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("ax9_edge%0d", k), RW'(ax[NUM-1]), (k == 10) ? 64'd10 : 64'd0);
      check($sformatf("ax0_edge%0d", k), RW'(ax[0]), (k == 1) ? 64'd1 : 64'd0);
      check($sformatf("out_valid_edge%0d", k), RW'(out_valid), (k == 14) ? 64'd1 : 64'd0);
    end
    wait_drain("single", 50);
    check("single_popped", RW'(n_pop), 1);

    // Back-to-back stream of all table vectors
    base = n_pop;
    for (int i = 0; i < NVEC; i++) send(i);
    in_valid = 1'b0;
    wait_drain("stream", 400);
    check("stream_count", RW'(n_pop - base), NVEC);

    // Backpressure: FIFO_DEPTH accepts then in_ready held low
    out_ready = 1'b0;
    base = n_pop;
    j = 0;
    for (int c = 0; c < 60; c++) begin
      drive(tbl[j].x, tbl[j].y, tbl[j].exp);
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) j++;
    end
    check("bp_accepted", RW'(j), FD);
    check("bp_in_ready_low", RW'(in_ready), 0);
    check("bp_out_valid", RW'(out_valid), 1);
    check("bp_head", out_result, tbl[0].exp);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain("bp", 200);
    check("bp_drained", RW'(n_pop - base), FD);

    // Flush with three vectors in flight
    base = n_pop;
    for (int i = 10; i < 13; i++) send(i);
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_in_ready_low", RW'(in_ready), 0);
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      tick();
      if (flush_done) seen = 1'b1;
      else check("drain_in_ready_low", RW'(in_ready), 0);
    end
    check("flush_done_seen", RW'(seen), 1);
    check("flush_popped", RW'(n_pop - base), 3);
    check("flush_done_timing", RW'(cyc - last_pop_edge), 1);
    tick();
    check("flush_done_one_pulse", RW'(flush_done), 0);
    check("in_ready_after_flush", RW'(in_ready), 1);

    // Reset mid-stream with five vectors in flight
    base = n_pop;
    for (int i = 13; i < 18; i++) send(i);
    in_valid = 1'b0;
    tick();
    check("pre_rst_axay_busy", RW'(ax != '0 || ay != '0), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_axay_zero", RW'(ax == '0 && ay == '0), 1);
    check("mid_rst_in_ready", RW'(in_ready), 0);
    check("mid_rst_out_valid", RW'(out_valid), 0);
    check("mid_rst_out_result", out_result, 0);
    check("mid_rst_flush_done", RW'(flush_done), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int t = 0; t < 30; t++) begin
      tick();
      check($sformatf("no_stale_%0d", t), RW'(out_valid), 0);
    end
    check("no_stale_pops", RW'(n_pop - base), 0);
    send(18);
    in_valid = 1'b0;
    wait_drain("post_rst", 60);
    check("post_rst_popped", RW'(n_pop - base), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dsp_systolic_27x27u_feeder.md
DSP_SYSTOLIC_27X27U_FEEDER -- requirements
Module: dsp_systolic_27x27u_feeder

Interface
REQ-001 SHALL have parameter NUM, default 10: number of systolic taps.
REQ-002 SHALL have parameter AX_WIDTH, default 27: x-operand width, unsigned.
REQ-003 SHALL have parameter AY_WIDTH, default 27: y-operand width, unsigned.
REQ-004 SHALL have parameter RESULT_A_WIDTH, default 64: chain result width.
REQ-005 SHALL have parameter CHAIN_LATENCY, default 3: cycles from last-tap operands to chain result.
REQ-006 SHALL have parameter FIFO_DEPTH, default 8, power of two, >=2: result buffer entries.
REQ-007 SHALL have ports:
  clk  in  1  sole clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  in_ax  in  NUM x AX_WIDTH  dot-product x vector
  in_ay  in  NUM x AY_WIDTH  dot-product y vector
  in_valid  in  1  vector offered
  in_ready  out  1  vector accepted when in_valid && in_ready
  ax  out  NUM x AX_WIDTH  skewed x operands to chain
  ay  out  NUM x AY_WIDTH  skewed y operands to chain
  result  in  RESULT_A_WIDTH  chain accumulate output
  out_result  out  RESULT_A_WIDTH  dot-product result
  out_valid  out  1  out_result valid
  out_ready  in  1  consumer accepts when out_valid && out_ready
  flush  in  1  level request to drain
  flush_done  out  1  one-cycle pulse, drain complete

Function
REQ-008 SHALL, on acceptance at edge T, drive lane i of ax/ay with the accepted element i from edge T+1+i through edge T+2+i (one cycle), i = 0..NUM-1.
REQ-009 SHALL drive zero on every lane slot not carrying an accepted element (bubbles contribute zero product).
REQ-010 SHALL sample result into the FIFO at edge T+NUM+CHAIN_LATENCY for each vector accepted at T, tracked by a NUM+CHAIN_LATENCY-deep valid shift register.
REQ-011 SHALL keep an in-flight counter: +1 on accept, -1 on capture, unchanged when both occur in one cycle.
REQ-012 SHALL drive in_ready = (in-flight + FIFO occupancy < FIFO_DEPTH) && state == RUN; FIFO overflow is therefore impossible.
REQ-013 SHALL present FIFO head on out_result with out_valid = FIFO non-empty; first-word latency from capture edge is one cycle.
REQ-014 SHALL handle simultaneous capture and pop on full FIFO without loss; pointers wrap modulo FIFO_DEPTH.
REQ-015 SHALL hold out_result/out_valid stable while out_valid && !out_ready.
REQ-016 SHALL implement FSM RUN -> DRAIN when flush sampled high; DRAIN -> DONE when in-flight == 0 and FIFO empty; DONE pulses flush_done one cycle then -> RUN if flush low, else stays DONE (no further pulse).
REQ-017 SHALL force in_ready low in DRAIN and DONE; vectors already in flight complete normally.
REQ-018 SHALL compute nothing arithmetically; operands pass unmodified, result width unchanged.

Reset
REQ-019 SHALL, while rst_n low: ax/ay all zero, in_ready 0, out_valid 0, out_result 0, flush_done 0, counters/pointers/valid pipe zero, FSM RUN.
REQ-020 SHALL assert in_ready the first cycle after rst_n deasserts (if flush low).
REQ-021 SHALL discard all in-flight and buffered results on reset mid-operation; no stale out_valid afterwards.

Structure
REQ-022 SHALL place FSM state enum and default width constants in package dsp_systolic_pkg.
REQ-023 SHALL implement the result buffer as sub-module dsp_systolic_result_fifo (sync FIFO, count output).

Verification
REQ-024 Single vector in_ax[i]=i+1, in_ay[i]=2 at edge 0 -> ax[9]=10 at edge 10 only; out_valid rises edge 14 with chain model value 110.
REQ-025 Back-to-back 20 vectors, out_ready=1 -> in_ready never drops, 20 results in order matching NUM-tap MAC model.
REQ-026 out_ready=0, continuous in_valid -> exactly 8 accepted, in_ready low thereafter, 8 results held; release -> all drain in order.
REQ-027 flush pulse with 3 in flight -> in_ready low immediately, flush_done one pulse after 3rd result popped, in_ready returns next cycle.
REQ-028 rst_n low mid-stream with 5 in flight -> all outputs zero asynchronously; after release no result emerges for pre-reset vectors.
